// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave front end: bus-ownership states and
// the idle (released) level of an open-drain I2C line.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TOUT = 2'd2
  } i2c_bus_st_t;

  localparam logic I2C_LINE_IDLE = 1'b1;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Per-line conditioner: a SYNC_STAGES-deep synchronizer followed by a
// stability filter. The filtered level only follows the synchronized line
// after it has disagreed for FILT_CNT consecutive cycles. The next filtered
// value is exported so the parent can register edge strobes on the same
// clock edge that updates the filtered output.
module i2c_glitch_filter
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic f,
  output logic f_nxt
);

  localparam int CNT_W = $clog2(FILT_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchronizer chain; resets to the released line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {SYNC_STAGES{I2C_LINE_IDLE}};
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  // Stability counter: count disagreement, accept the new level on the last count.
  always_comb begin
    cnt_d = '0;
    f_nxt = f;
    if (s != f) begin
      if (cnt_q == CNT_LAST) f_nxt = s;
      else                   cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Filtered level and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f     <= I2C_LINE_IDLE;
      cnt_q <= '0;
    end else begin
      f     <= f_nxt;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_bus_cond.sv
// I2C bus line conditioner and bus-state controller. Filters SCL/SDA,
// decodes SCL edges and START / repeated-START / STOP conditions from the
// current and next filtered levels, tracks bus ownership and flags an SCL
// held low for too long while the bus is owned. Every output is registered.
module i2c_bus_cond
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT    = 3,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_f,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic rstart_det,
  output logic stop_det,
  output logic bus_busy,
  output logic timeout
);

  localparam int TO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

  logic scl_n, sda_n;
  logic start_c, stop_c, to_hit;
  logic start_d, rstart_d, stop_d, tout_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  i2c_bus_st_t state_q, state_d;

  i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CNT(FILT_CNT)) u_scl_filt (
    .clk   (clk),
    .rst   (rst),
    .din   (scl_i),
    .f     (scl_f),
    .f_nxt (scl_n)
  );

  i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CNT(FILT_CNT)) u_sda_filt (
    .clk   (clk),
    .rst   (rst),
    .din   (sda_i),
    .f     (sda_f),
    .f_nxt (sda_n)
  );

  // SDA may only count as START/STOP while SCL is high both before and after,
  // so a simultaneous change of both lines is only an SCL edge.
  assign start_c = scl_f & scl_n &  sda_f & ~sda_n;
  assign stop_c  = scl_f & scl_n & ~sda_f &  sda_n;

  // SCL-low run length while the bus is owned; saturates, clears otherwise.
  always_comb begin
    to_cnt_d = '0;
    if (en && (state_q == BUSY) && !scl_f) begin
      if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + TO_W'(1);
      else                    to_cnt_d = to_cnt_q;
    end
  end

  assign to_hit = (TIMEOUT_CYC != 0) && (state_q == BUSY) && (to_cnt_d == TO_MAX);

  // Bus-state next-state and strobe decode.
  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    rstart_d = 1'b0;
    stop_d   = 1'b0;
    tout_d   = 1'b0;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_c) begin
            state_d = BUSY;
            start_d = 1'b1;
          end else if (stop_c) begin
            stop_d = 1'b1;
          end
        end
        BUSY: begin
          if (start_c) begin
            rstart_d = 1'b1;
          end else if (stop_c) begin
            state_d = IDLE;
            stop_d  = 1'b1;
          end else if (to_hit) begin
            state_d = TOUT;
            tout_d  = 1'b1;
          end
        end
        TOUT: begin
          if (start_c) begin
            state_d = BUSY;
            start_d = 1'b1;
          end else if (stop_c) begin
            state_d = IDLE;
            stop_d  = 1'b1;
          end else if (scl_f && sda_f) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, timeout counter and strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      to_cnt_q   <= '0;
      scl_rise   <= 1'b0;
      scl_fall   <= 1'b0;
      start_det  <= 1'b0;
      rstart_det <= 1'b0;
      stop_det   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      scl_rise   <= en & ~scl_f &  scl_n;
      scl_fall   <= en &  scl_f & ~scl_n;
      start_det  <= start_d;
      rstart_det <= rstart_d;
      stop_det   <= stop_d;
      timeout    <= tout_d;
    end
  end

  assign bus_busy = (state_q != IDLE);

endmodule

// File: doc/i2c_bus_cond.md
# i2c_bus_cond

I2C bus line conditioner and bus-state controller for the slave front end. It synchronizes raw SCL/SDA into `clk`, rejects glitches with a per-line stability filter, and emits single-cycle SCL edge and START / repeated-START / STOP strobes. It tracks bus ownership (free/busy) and flags SCL-low timeouts. All downstream slave logic (shift register, address match, ACK FSM) consumes only this block's outputs, never the raw pins.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages per line before the filter; minimum 2.
- `FILT_CNT`, default 3: consecutive stable post-sync cycles needed to accept a level change; minimum 1.
- `TIMEOUT_CYC`, default 20000: consecutive `scl_f`-low cycles in BUSY that trigger a timeout; 0 disables the timeout.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: block enable. When 0, strobes are suppressed and the FSM is held in IDLE. Sync and filter keep running.
- `scl_i` in 1: raw SCL pin.
- `sda_i` in 1: raw SDA pin.
- `scl_f` out 1: filtered SCL; reset value 1.
- `sda_f` out 1: filtered SDA; reset value 1.
- `scl_rise` out 1: one-cycle pulse on `scl_f` 0→1; reset value 0.
- `scl_fall` out 1: one-cycle pulse on `scl_f` 1→0; reset value 0.
- `start_det` out 1: one-cycle pulse on START from IDLE; reset value 0.
- `rstart_det` out 1: one-cycle pulse on START while BUSY (repeated START); reset value 0.
- `stop_det` out 1: one-cycle pulse on STOP; reset value 0.
- `bus_busy` out 1: high in BUSY and TOUT; reset value 0.
- `timeout` out 1: one-cycle pulse on entering TOUT; reset value 0.

## Operation
- **Synchronizer:** `SYNC_STAGES`-deep chain per line, reset to 1.
- **Filter (per line):**
  - Filtered register `f` resets to 1. Counter `cnt` has width $clog2(FILT_CNT+1) and resets to 0.
  - If sync ≠ `f`: `cnt` increments. When `cnt` == FILT_CNT-1, `f` takes the sync value and `cnt` clears.
  - If sync == `f`: `cnt` clears. A glitch shorter than FILT_CNT cycles never reaches `f`.
- **Event decode:** registered, using previous (`p`) and next (`n`) filtered values.
  - `scl_rise`/`scl_fall` follow `scl_f` transitions.
  - START: `sda_f` 1→0 with `scl_f` p=1 and n=1.
  - STOP: `sda_f` 0→1 with `scl_f` p=1 and n=1.
  - `scl_f` and `sda_f` changing in the same cycle produce only the SCL edge strobe, never START or STOP.
- **FSM states:** IDLE, BUSY, TOUT.
  - IDLE→BUSY on START, with `start_det`.
  - BUSY→BUSY on START, with `rstart_det`. The timeout counter clears.
  - BUSY→IDLE on STOP, with `stop_det`.
  - BUSY→TOUT when the timeout counter reaches TIMEOUT_CYC, with `timeout` pulsed once.
  - TOUT→IDLE in the first cycle in which `scl_f`=1 and `sda_f`=1. A STOP in TOUT also returns to IDLE, with `stop_det`.
  - STOP seen in IDLE: `stop_det` pulses; state stays IDLE.
  - START seen in TOUT: go to BUSY with `start_det` (not `rstart_det`).
- **Timeout counter:**
  - Width $clog2(TIMEOUT_CYC+1).
  - Counts in BUSY while `scl_f`=0 and saturates at TIMEOUT_CYC.
  - Clears when `scl_f`=1 or the state is not BUSY.
- **`en`=0:** FSM forced to IDLE, timeout counter cleared, all strobes held 0. `scl_f` and `sda_f` still track the lines. Re-enabling mid-transfer stays in IDLE until the next START.
- **`rst` mid-transfer:** all state returns to reset values immediately, asynchronously. No strobes fire on reset release.

## Timing
- Raw-pin change held stable → `scl_f`/`sda_f` change after SYNC_STAGES + FILT_CNT cycles.
- Edge, START, STOP and `timeout` strobes are asserted in the same cycle the filtered value changes: the same edge updates the filter output and the strobe registers.
- `bus_busy` rises in the same cycle as `start_det` and falls in the same cycle as `stop_det`.
- `timeout` asserts at the cycle edge ending the TIMEOUT_CYC-th low cycle; `bus_busy` stays 1 through TOUT.
- All strobes are exactly one cycle wide. No output is combinational from the pins.

## Structure
- Shared package `i2c_pkg` holds:
  - the bus-state enum `i2c_bus_st_t` {IDLE, BUSY, TOUT};
  - the constant `I2C_LINE_IDLE` = 1'b1.
- Sub-module `i2c_glitch_filter` (parameter FILT_CNT) contains the synchronizer chain plus the stability counter, instantiated once for SCL and once for SDA.
- Top level contains the event decode, FSM and timeout counter.

## Test plan
- Reset, then both pins held at 1 → `scl_f`=`sda_f`=1, all strobes 0, `bus_busy`=0.
- SDA low with SCL high, defaults → `sda_f` falls 5 cycles after the pin; `start_det`=1 and `bus_busy`=1 in that same cycle.
- 2-cycle SCL low glitch with FILT_CNT=3 → `scl_f` stays 1, no `scl_fall`. A 3-cycle low → `scl_fall` pulses once.
- START, 9 SCL clocks, START, STOP → `start_det` ×1, `scl_rise` ×9, `rstart_det` ×1, then `stop_det` with `bus_busy` 1→0.
- TIMEOUT_CYC=50: START, then SCL held low → `timeout` pulses 50 cycles after `scl_fall`. Releasing both lines returns to IDLE with `bus_busy`=0.
- SCL and SDA pins toggled in the same cycle while BUSY → only the SCL edge strobe; no START/STOP. Assert `rst` mid-byte → every output returns to its reset value within the same cycle.
